gpio_arbiter: RTL and testbench
===============================

GPIO_ARBITER -- requirements
Module: gpio_arbiter

Interface
REQ-001 Parameter: RESET_VAL, 32'h0, gpio_out_data value at reset.
REQ-002 Parameter: LOCK_TIMEOUT, 255, idle cycles before a held lock is force-released (lock build only).
REQ-003 Ports: clk  in  1  sole clock; all state rising-edge.
REQ-004 Ports: resetn  in  1  asynchronous, active-low reset.
REQ-005 Ports: req_valid  in  2  per-requester write request (bit0 = CPU bus, bit1 = logic-analyser engine).
REQ-006 Ports: req_wstrb0 / req_wstrb1  in  4 each  byte strobes.
REQ-007 Ports: req_wdata0 / req_wdata1  in  32 each  write data.
REQ-008 Ports: req_lock  in  2  hold-grant request (lock build only).
REQ-009 Ports: req_ready  out  2  one-cycle acceptance pulse.
REQ-010 Ports: gpio_out_data  out  32  registered GPIO output value.
REQ-011 Ports: owner  out  1  index of last granted requester.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT and LOCKED; LOCKED is reachable only in the lock build.
REQ-013 In IDLE with any req_valid set, the block SHALL register a winner and enter GRANT on the next edge.
REQ-014 Winner selection SHALL be round-robin: with a single request, that requester wins; with both, the requester that is not owner wins.
REQ-015 In GRANT, req_ready[winner] SHALL be high for exactly one cycle, and the other bit SHALL be low.
REQ-016 At the end of GRANT, each byte i of gpio_out_data with wstrb[i]=1 SHALL load the winner's wdata byte, and unstrobed bytes SHALL hold.
REQ-017 Timing: valid sampled in IDLE at cycle N; ready in N+1; new data visible N+2; peak throughput 1 write per 2 cycles.
REQ-018 Requesters SHALL hold valid, wstrb and wdata stable until ready; a request dropped before ready is undefined and not checked.
REQ-019 wstrb=4'b0000 SHALL still complete the handshake and leave data unchanged.
REQ-020 After GRANT, the FSM SHALL return to IDLE, or go to LOCKED per REQ-027; owner SHALL update to the winner at the same edge.
REQ-021 req_ready SHALL never be asserted in IDLE or LOCKED-wait cycles.

Reset
REQ-022 Asserting resetn low at any time, including mid-GRANT, SHALL immediately force: state IDLE, req_ready=0, gpio_out_data=RESET_VAL, owner=1 (so requester 0 wins first tie), and lock counter=0.
REQ-023 A write whose GRANT is cut by reset SHALL NOT take effect.
REQ-024 After resetn deasserts, the first request SHALL be sampled on the next rising edge.

Configuration
REQ-025 The macro GPIO_ARBITER_LOCK_EN SHALL control the lock feature.
REQ-026 Without GPIO_ARBITER_LOCK_EN: the req_lock port and LOCKED state SHALL be absent, and LOCK_TIMEOUT SHALL be unused.
REQ-027 With the macro, a GRANT whose winner had req_lock=1 SHALL enter LOCKED.
REQ-028 In LOCKED, only owner's req_valid SHALL be honoured (-> GRANT), and the other requester SHALL wait indefinitely.
REQ-029 LOCKED SHALL exit to IDLE after a GRANT with owner's req_lock=0.
REQ-030 LOCKED SHALL also exit to IDLE when owner's req_valid stays low for LOCK_TIMEOUT consecutive cycles; the counter SHALL clear on any owner valid.

Structure
REQ-031 Package gpio_arbiter_pkg SHALL hold the state enum (IDLE/GRANT/LOCKED) and requester index constants REQ_CPU=0 and REQ_LA=1.
REQ-032 Round-robin pick logic SHALL be one sub-module, gpio_arbiter_rr (inputs: valid, owner; output: winner).

Verification
REQ-033 Single write: req0 wdata=32'hA5A5_1234, wstrb=4'b1111 from reset -> ready0 at cycle 1, gpio_out_data=32'hA5A5_1234 at cycle 2.
REQ-034 Byte merge: data=32'hFFFF_FFFF, req1 wdata=0, wstrb=4'b0101 -> 32'hFF00_FF00.
REQ-035 Contention: both valid continuously -> grants alternate 0,1,0,1; each ready is a 1-cycle pulse, 2 cycles apart.
REQ-036 Reset mid-GRANT: resetn low during ready0 cycle -> gpio_out_data=RESET_VAL and ready=0 immediately; the write is lost.
REQ-037 LOCK_EN: req1 sends 3 writes with lock=1,1,0 while req0 is valid -> req0 is served only after the third write.
REQ-038 LOCK_EN timeout: LOCK_TIMEOUT=4, req0 locks then idles -> IDLE after 4 cycles, and the pending req1 is granted.

Source files
------------

// File: rtl/gpio_arbiter_pkg.sv
// Shared types and constants for the two-requester GPIO write arbiter.
// Imported by gpio_arbiter and gpio_arbiter_rr.
package gpio_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LA  = 1'b1;

  localparam int unsigned NREQ = 2;
  localparam int unsigned DW   = 32;
  localparam int unsigned SW   = DW / 8;

  function automatic logic [DW-1:0] merge_bytes(
    input logic [DW-1:0] cur,
    input logic [DW-1:0] wdata,
    input logic [SW-1:0] wstrb
  );
    logic [DW-1:0] res;
    res = cur;
    for (int i = 0; i < SW; i++) begin
      if (wstrb[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/gpio_arbiter_rr.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to
// whichever requester is not the current owner.
module gpio_arbiter_rr
  import gpio_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] valid,
  input  logic            owner,
  output logic            winner
);

  always_comb begin
    winner = ~owner;
    unique case (valid)
      2'b01:   winner = REQ_CPU;
      2'b10:   winner = REQ_LA;
      default: winner = ~owner;
    endcase
  end

endmodule

// File: rtl/gpio_arbiter.sv
// Round-robin GPIO write arbiter with byte-strobed output register.
// Optional hold-grant lock with idle timeout under GPIO_ARBITER_LOCK_EN.
module gpio_arbiter
  import gpio_arbiter_pkg::*;
#(
  parameter logic [31:0] RESET_VAL    = 32'h0,
  parameter int unsigned LOCK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  req_valid,
  input  logic [3:0]  req_wstrb0,
  input  logic [3:0]  req_wstrb1,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
`ifdef GPIO_ARBITER_LOCK_EN
  input  logic [1:0]  req_lock,
`endif
  output logic [1:0]  req_ready,
  output logic [31:0] gpio_out_data,
  output logic        owner
);

  state_e      state_q, state_d;
  logic        winner_q, winner_d;
  logic        owner_q, owner_d;
  logic [31:0] data_q, data_d;
  logic        rr_winner;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;

`ifdef GPIO_ARBITER_LOCK_EN
  localparam int unsigned CW =
    (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
`endif

  gpio_arbiter_rr u_rr (
    .valid  (req_valid),
    .owner  (owner_q),
    .winner (rr_winner)
  );

  assign sel_wdata = winner_q ? req_wdata1 : req_wdata0;
  assign sel_wstrb = winner_q ? req_wstrb1 : req_wstrb0;

  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    owner_d   = owner_q;
    data_d    = data_q;
    req_ready = '0;
`ifdef GPIO_ARBITER_LOCK_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          winner_d = rr_winner;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        req_ready[winner_q] = 1'b1;
        data_d  = merge_bytes(data_q, sel_wdata, sel_wstrb);
        owner_d = winner_q;
        state_d = IDLE;
`ifdef GPIO_ARBITER_LOCK_EN
        cnt_d   = '0;
        if (req_lock[winner_q]) state_d = LOCKED;
`endif
      end
      LOCKED: begin
`ifdef GPIO_ARBITER_LOCK_EN
        // Only the lock holder may proceed; the other side waits.
        if (req_valid[owner_q]) begin
          winner_d = owner_q;
          cnt_d    = '0;
          state_d  = GRANT;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          cnt_d    = cnt_q + CW'(1);
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      winner_q <= REQ_CPU;
      owner_q  <= REQ_LA;
      data_q   <= RESET_VAL;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      owner_q  <= owner_d;
      data_q   <= data_d;
    end
  end

`ifdef GPIO_ARBITER_LOCK_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`endif

  assign gpio_out_data = data_q;
  assign owner         = owner_q;

endmodule

// File: tb/tb_gpio_arbiter.sv
// Directed self-checking bench for gpio_arbiter.
// Lock scenarios run only when GPIO_ARBITER_LOCK_EN is defined.
module tb_gpio_arbiter;
  import gpio_arbiter_pkg::*;

  localparam logic [31:0] RV = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [3:0]  req_wstrb0 = '0;
  logic [3:0]  req_wstrb1 = '0;
  logic [31:0] req_wdata0 = '0;
  logic [31:0] req_wdata1 = '0;
  logic [1:0]  req_ready;
  logic [31:0] gpio_out_data;
  logic        owner;
`ifdef GPIO_ARBITER_LOCK_EN
  logic [1:0]  req_lock = '0;
`endif

  int checks = 0;
  int failures = 0;

  gpio_arbiter #(
    .RESET_VAL    (RV),
    .LOCK_TIMEOUT (4)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_wstrb0    (req_wstrb0),
    .req_wstrb1    (req_wstrb1),
    .req_wdata0    (req_wdata0),
    .req_wdata1    (req_wdata1),
`ifdef GPIO_ARBITER_LOCK_EN
    .req_lock      (req_lock),
`endif
    .req_ready     (req_ready),
    .gpio_out_data (gpio_out_data),
    .owner         (owner)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    req_valid = '0;
`ifdef GPIO_ARBITER_LOCK_EN
    req_lock  = '0;
`endif
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_w;

    do_reset();
    check("rst_data", gpio_out_data, RV);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_owner", 32'(owner), 32'h1);

    // single write from reset
    req_wdata0 = 32'hA5A5_1234;
    req_wstrb0 = 4'b1111;
    req_valid  = 2'b01;
    tick();
    check("w1_ready", 32'(req_ready), 32'h1);
    check("w1_data_old", gpio_out_data, RV);
    tick();
    req_valid = '0;
    check("w1_data", gpio_out_data, 32'hA5A5_1234);
    check("w1_ready_off", 32'(req_ready), 32'h0);
    check("w1_owner", 32'(owner), 32'h0);

    // byte merge
    req_wdata1 = 32'hFFFF_FFFF;
    req_wstrb1 = 4'b1111;
    req_valid  = 2'b10;
    tick();
    check("bm1_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    check("bm1_data", gpio_out_data, 32'hFFFF_FFFF);
    req_wdata1 = 32'h0;
    req_wstrb1 = 4'b0101;
    req_valid  = 2'b10;
    tick();
    check("bm2_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    check("bm2_data", gpio_out_data, 32'hFF00_FF00);
    check("bm2_owner", 32'(owner), 32'h1);

    // empty strobe still handshakes
    req_wdata0 = 32'h1234_5678;
    req_wstrb0 = 4'b0000;
    req_valid  = 2'b01;
    tick();
    check("zs_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    check("zs_data", gpio_out_data, 32'hFF00_FF00);
    check("zs_owner", 32'(owner), 32'h0);

    // contention: owner is 0, so requester 1 goes first
    req_wdata0 = 32'h0000_AAAA;
    req_wdata1 = 32'h0000_BBBB;
    req_wstrb0 = 4'b1111;
    req_wstrb1 = 4'b1111;
    req_valid  = 2'b11;
    exp_w = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ct_ready", 32'(req_ready),
            exp_w ? 32'h2 : 32'h1);
      tick();
      check("ct_gap", 32'(req_ready), 32'h0);
      check("ct_data", gpio_out_data,
            exp_w ? 32'h0000_BBBB : 32'h0000_AAAA);
      exp_w = ~exp_w;
    end
    req_valid = '0;

    // reset cuts a grant in flight
    req_wdata0 = 32'hCAFE_F00D;
    req_valid  = 2'b01;
    tick();
    check("rg_ready", 32'(req_ready), 32'h1);
    resetn = 1'b0;
    #1;
    check("rg_ready_rst", 32'(req_ready), 32'h0);
    check("rg_data_rst", gpio_out_data, RV);
    check("rg_owner_rst", 32'(owner), 32'h1);
    req_valid = '0;
    tick();
    tick();
    resetn = 1'b1;
    check("rg_lost", gpio_out_data, RV);

    // first request after reset release
    req_wdata1 = 32'h0BAD_CAFE;
    req_wstrb1 = 4'b0011;
    req_valid  = 2'b10;
    tick();
    check("pr_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    check("pr_data", gpio_out_data, 32'h1357_CAFE);

`ifdef GPIO_ARBITER_LOCK_EN
    // lock held by requester 1 for three writes
    do_reset();
    req_wstrb0 = 4'b1111;
    req_wstrb1 = 4'b1111;
    req_wdata0 = 32'h4444_4444;
    req_wdata1 = 32'h1111_1111;
    req_lock   = 2'b10;
    req_valid  = 2'b10;
    tick();
    check("lk1_ready", 32'(req_ready), 32'h2);
    tick();
    check("lk1_data", gpio_out_data, 32'h1111_1111);
    req_valid  = 2'b11;
    req_wdata1 = 32'h2222_2222;
    tick();
    check("lk2_ready", 32'(req_ready), 32'h2);
    tick();
    check("lk2_data", gpio_out_data, 32'h2222_2222);
    req_wdata1 = 32'h3333_3333;
    req_lock   = 2'b00;
    tick();
    check("lk3_ready", 32'(req_ready), 32'h2);
    tick();
    check("lk3_data", gpio_out_data, 32'h3333_3333);
    req_valid = 2'b01;
    tick();
    check("lk4_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    check("lk4_data", gpio_out_data, 32'h4444_4444);

    // lock timeout releases a pending requester
    do_reset();
    req_wdata0 = 32'h5555_5555;
    req_wdata1 = 32'h6666_6666;
    req_lock   = 2'b01;
    req_valid  = 2'b01;
    tick();
    check("to_ready0", 32'(req_ready), 32'h1);
    tick();
    check("to_data0", gpio_out_data, 32'h5555_5555);
    req_lock  = '0;
    req_valid = 2'b10;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("to_wait", 32'(req_ready), 32'h0);
    end
    tick();
    check("to_ready1", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    check("to_data1", gpio_out_data, 32'h6666_6666);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
